// File: rtl/ldpc_rx_fill_8160_7136.sv
// ---------------------------------------------------------------------------
// ldpc_rx_fill_8160_7136
//
// Receive-side framing adapter for the (8160,7136) LDPC link. It sits between
// the hard-decision front end and an (8176,7154) decoder core. For every
// received 8160-bit codeword (7136 info + 1022 parity + 2 pad bits) it emits
// one 8176-bit decoder frame:
//   18 known-zero virtual-fill bits ++ first 8158 received bits.
// The 2 trailing pad bits are stripped and checked for zero.
//
// Bits travel MSB first: tdata[width-1] is the earliest bit of a beat.
// Supported beat widths: 1, 8, 16.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   s_axis_tdata   received codeword bits          (width)
//   s_axis_tvalid  input beat valid
//   s_axis_tready  input beat accepted
//   m_axis_tdata   decoder-frame bits              (width)
//   m_axis_tvalid  output beat valid
//   m_axis_tlast   last beat of each 8176-bit frame
//   m_axis_tready  downstream ready
//   pad_err        one-cycle pulse when a frame's 2 pad bits are not both 0
//
// Datapath is combinational from s_axis_tdata to m_axis_tdata; only the FSM,
// the 13-bit output-beat counter, the residual bits and pad_err are stored.
// ---------------------------------------------------------------------------
module ldpc_rx_fill_8160_7136 #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [width-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             pad_err
);

    localparam int OUT_BEATS = 8176 / width;
    // Whole zero beats that precede the first body beat.
    localparam int NZ        = 18 / width;
    // Fill zeros that do not make a whole beat; they ride in the residual
    // register at the head of the first body beat.
    localparam int R         = 18 % width;

    localparam logic [12:0] LAST_BEAT = 13'(OUT_BEATS - 1);
    localparam logic [12:0] LAST_ZERO = 13'(NZ - 1);

    typedef enum logic [1:0] {
        ST_ZERO = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] beat_q,  beat_d;    // output beat index inside the frame
    logic        drop_q,  drop_d;    // pad beat index while dropping (width 1)
    logic        pad_err_q;

    logic [width-1:0] body_data;
    logic             m_xfer;
    logic             s_xfer;
    logic             at_last;

    assign at_last = (beat_q == LAST_BEAT);
    assign m_xfer  = m_axis_tvalid & m_axis_tready;
    assign s_xfer  = s_axis_tvalid & s_axis_tready;
    assign pad_err = pad_err_q;

    // -----------------------------------------------------------------------
    // Handshake / output mux. Everything is forced low while rst is high so
    // the downstream core sees an idle bus during reset.
    // -----------------------------------------------------------------------
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_ZERO: begin
                    // Fill zeros go out only once a codeword is actually
                    // arriving; the waiting input beat is left untouched.
                    m_axis_tvalid = s_axis_tvalid;
                end
                ST_BODY: begin
                    // One input beat per output beat, so input ready simply
                    // follows output ready and the data is held for free
                    // while the output stalls.
                    m_axis_tvalid = s_axis_tvalid;
                    s_axis_tready = m_axis_tready;
                    m_axis_tdata  = body_data;
                    m_axis_tlast  = at_last;
                end
                ST_DROP: begin
                    s_axis_tready = 1'b1;
                end
                default: begin
                    s_axis_tready = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Frame sequencing
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drop_d  = drop_q;
        case (state_q)
            ST_ZERO: begin
                if (m_xfer) begin
                    if (beat_q == LAST_ZERO) begin
                        state_d = ST_BODY;
                    end
                    beat_d = beat_q + 13'd1;
                end
            end
            ST_BODY: begin
                if (m_xfer) begin
                    if (at_last) begin
                        beat_d = '0;
                        // With wider beats the pad bits are the low bits of
                        // the final input beat and vanish with the residual.
                        // At width 1 they still have to be pulled off the
                        // input one beat at a time.
                        state_d = (width == 1) ? ST_DROP : ST_ZERO;
                    end else begin
                        beat_d = beat_q + 13'd1;
                    end
                end
            end
            ST_DROP: begin
                if (s_xfer) begin
                    drop_d = ~drop_q;
                    if (drop_q) begin
                        state_d = ST_ZERO;
                    end
                end
            end
            default: begin
                state_d = ST_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ZERO;
            beat_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drop_q  <= drop_d;
        end
    end

    // -----------------------------------------------------------------------
    // Realignment and pad check
    // -----------------------------------------------------------------------
    generate
        if (R > 0) begin : g_res
            // The low R bits of each input beat belong to the next output
            // beat; they are parked here for one transfer.
            logic [R-1:0] res_q, res_d;

            always_comb begin
                res_d = res_q;
                if (state_q == ST_BODY && s_xfer) begin
                    // On the frame's last beat these low bits are the pad
                    // bits: discard them so the next frame starts with the
                    // residual holding fill zeros.
                    res_d = at_last ? '0 : s_axis_tdata[R-1:0];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q     <= '0;
                    pad_err_q <= 1'b0;
                end else begin
                    res_q     <= res_d;
                    pad_err_q <= (state_q == ST_BODY) && m_xfer && at_last &&
                                 (s_axis_tdata[1:0] != 2'b00);
                end
            end

            // body = {res, s_axis_tdata[width-1:R]}
            for (genvar gi = 0; gi < width; gi++) begin : g_bit
                if (gi >= width - R) begin : g_from_res
                    assign body_data[gi] = res_q[gi-(width-R)];
                end else begin : g_from_in
                    assign body_data[gi] = s_axis_tdata[gi+R];
                end
            end
        end else begin : g_direct
            // Beat boundaries line up with the fill: pass straight through
            // and inspect the pad bits as they are dropped.
            logic pad_first_q;

            assign body_data = s_axis_tdata;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pad_first_q <= 1'b0;
                    pad_err_q   <= 1'b0;
                end else begin
                    pad_err_q <= 1'b0;
                    if (state_q == ST_DROP && s_xfer) begin
                        if (!drop_q) begin
                            pad_first_q <= s_axis_tdata[0];
                        end else begin
                            pad_err_q <= pad_first_q | s_axis_tdata[0];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: doc/ldpc_rx_fill_8160_7136.md
Name: ldpc_rx_fill_8160_7136

Overview:
- Receive-side framing adapter for the CCSDS (8160,7136) LDPC link, placed between the channel/hard-decision front end and an (8176,7154) decoder core.
- Each received 8160-bit codeword is laid out as 7136 info bits, then 1022 parity bits, then 2 pad bits.
- Per codeword, the block prepends the 18 known-zero virtual-fill bits, strips the 2 trailing pad bits and emits one 8176-bit frame with tlast.
- It realigns the stream across beat boundaries and flags non-zero pad bits.

Parameters:
- width, 8: beat width in bits; supported values are 1, 8 and 16. Bit order is MSB first: tdata[width-1] is the earliest bit.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- s_axis_tdata  input  width  received codeword bits
- s_axis_tvalid  input  1  input beat valid
- s_axis_tready  output  1  input beat accepted
- m_axis_tdata  output  width  decoder-frame bits
- m_axis_tvalid  output  1  output beat valid
- m_axis_tlast  output  1  high on the last beat of each 8176-bit frame
- m_axis_tready  input  1  downstream ready
- pad_err  output  1  one-cycle pulse when a frame's 2 pad bits are not both 0

Behaviour:
- Constants:
  - IN_BEATS = 8160/width (1020 for width 8, 510 for width 16, 8160 for width 1).
  - OUT_BEATS = 8176/width.
  - NZ = floor(18/width): 2, 1 or 18.
  - R = 18 mod width: 2, 2 or 0.
- Transfers: a transfer occurs when valid and ready are both high at a clk edge.
- Reset: while rst is high, all outputs are 0, the FSM goes to ZERO, all counters clear and the residual register clears. A reset mid-frame discards the partial frame, and the next frame starts cleanly.
- FSM ZERO:
  - m_axis_tvalid = s_axis_tvalid. Zeros are emitted only once codeword data is present; the input beat is not consumed.
  - m_axis_tdata = 0 and s_axis_tready = 0.
  - Counts NZ output transfers, then moves to BODY.
- FSM BODY:
  - m_axis_tdata = {res[R-1:0], s_axis_tdata[width-1:R]}. For R=0 this is s_axis_tdata.
  - m_axis_tvalid = s_axis_tvalid and s_axis_tready = m_axis_tready, so one input beat maps to one output beat.
  - On each transfer, res <= s_axis_tdata[R-1:0]. res is 0 at the first body beat, which supplies the 2 remaining fill zeros.
  - m_axis_tlast is high on output beat OUT_BEATS-1.
  - After that transfer the FSM goes to ZERO if width is 8 or 16; the dropped pad bits are then the res content.
  - For width 1, after output beat 8175 the FSM goes to DROP.
- FSM DROP (width 1 only):
  - s_axis_tready = 1, m_axis_tvalid = 0.
  - Consumes 2 input beats (the pad bits), then returns to ZERO.
- Pad check: pad_err pulses for one cycle after the last input beat of a frame is consumed, if the 2 pad bits are non-zero.
- Datapath timing:
  - Zero-latency combinational path from s_axis_tdata to m_axis_tdata.
  - Only the FSM, output-beat counter (13 bits), residual and pad_err are registered.
- Handshake rules:
  - m_axis_tvalid never depends on m_axis_tready.
  - Data and last are held stable while valid and not ready, because input is not consumed until the output transfers.
- Counter rollover: the output-beat counter clears at each tlast transfer. Back-to-back frames need no idle cycle, apart from the NZ zero beats.

Test Plan:
- width=8, input frame of 1020 beats = 0xFF, pad bits 0, m_axis_tready=1 -> 1022 output beats:
  - beats 0-1 = 0x00, beat 2 = 0x3F, beats 3-1021 = 0xFF;
  - tlast only on beat 1021; pad_err stays 0.
- width=8, input beats = beat index mod 256 -> output beat k≥3 = {in[k-3][1:0], in[k-2][7:2]}. Last input 0xFB -> tlast beat = {in[1018][1:0],6'b111110} and pad_err pulses, since pad bits = 2'b11.
- width=16, random data, m_axis_tready toggled 50% -> 511 output beats per frame, bit-exact versus a golden model (18 zeros ++ first 8158 input bits). No data changes while valid and not ready.
- width=1 -> 18 zero beats, then 8158 passed bits with tlast on beat 8175, then 2 input beats consumed with m_axis_tvalid=0. Pad bits 1,0 -> pad_err=1.
- Three back-to-back frames with s_axis_tvalid gaps -> no zero beats emitted while s_axis_tvalid=0, and exactly 3 tlast pulses.
- rst asserted at output beat 500, then a full frame -> all outputs 0 during reset, and the following frame matches the golden model from beat 0.
